// File: rtl/lcm_cfg_bank.sv
// rtl/lcm_cfg_bank.sv - local-control register engine: buffers a control packet,
// executes one register read/write, and echoes the packet back with the result.
module lcm_cfg_bank #(
   parameter int          NUM_REGS  = 8,
   parameter int          NUM_STAT  = 4,
   parameter int          REG_W     = 64,
   parameter int          MAX_WORDS = 8,
   parameter int          CMD_WORD  = 0,
   parameter logic [63:0] REG_RST   = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [133:0]              in_pkt_data,
   input  logic                      in_pkt_data_wr,
   input  logic                      in_pkt_data_valid,
   input  logic                      in_pkt_data_valid_wr,
   output logic                      in_pkt_data_ready,
   output logic [133:0]              out_pkt_data,
   output logic                      out_pkt_data_wr,
   output logic                      out_pkt_data_valid,
   output logic                      out_pkt_data_valid_wr,
   input  logic                      out_pkt_data_ready,
   output logic [NUM_REGS*REG_W-1:0] cfg_regs,
   output logic [NUM_REGS-1:0]       cfg_wr_pulse,
   input  logic [NUM_STAT*64-1:0]    stat_in,
   output logic [15:0]               drop_cnt
);

   localparam int IW = $clog2(MAX_WORDS);
   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_FLUSH, S_EXEC, S_SEND} state_t;

   state_t        state;
   logic [133:0]  pkt_buf [2**IW];
   logic [CW-1:0] wcnt;
   logic [CW-1:0] rd_idx;

   logic take, is_head, is_tail, buf_full, good_tail, drop_ev;

   assign take      = in_pkt_data_wr && in_pkt_data_ready;
   assign is_head   = (in_pkt_data[133:132] == 2'b01);
   assign is_tail   = (in_pkt_data[133:132] == 2'b10);
   assign buf_full  = (wcnt == CW'(MAX_WORDS));
   assign good_tail = in_pkt_data_valid_wr && in_pkt_data_valid &&
                      ((32'(wcnt) + 32'd1) > 32'(CMD_WORD));
   assign drop_ev   = take && (state == S_RECV) &&
                      (is_head || buf_full || (is_tail && !good_tail));

   logic [133:0]        cmd;
   logic [47:0]         addr;
   logic                rd;
   logic [63:0]         wdata;
   logic [REG_W-1:0]    wtrunc;
   logic [NUM_REGS-1:0] reg_hit;
   logic                stat_hit;
   logic [63:0]         reg_word, stat_word, exec_data;
   logic                exec_err;

   assign cmd    = pkt_buf[IW'(CMD_WORD)];
   assign addr   = cmd[47:0];
   assign rd     = cmd[48];
   assign wdata  = cmd[119:56];
   assign wtrunc = wdata[REG_W-1:0];

   // Full 48-bit compare so aliases of valid addresses in the upper bits miss.
   always_comb begin
      reg_hit   = '0;
      stat_hit  = 1'b0;
      reg_word  = '0;
      stat_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == 48'(i)) begin
            reg_hit[i] = 1'b1;
            reg_word   = 64'(cfg_regs[i*REG_W +: REG_W]);
         end
      end
      for (int j = 0; j < NUM_STAT; j++) begin
         if (addr == 48'(NUM_REGS + j)) begin
            stat_hit  = 1'b1;
            stat_word = stat_in[j*64 +: 64];
         end
      end
   end

   always_comb begin
      exec_err  = 1'b0;
      exec_data = wdata;
      if (|reg_hit) begin
         exec_data = rd ? reg_word : 64'(wtrunc);
      end else if (stat_hit && rd) begin
         exec_data = stat_word;
      end else begin
         exec_err = 1'b1;
         if (rd) exec_data = '0;
      end
   end

   logic          buf_we;
   logic [IW-1:0] buf_widx;
   logic [133:0]  buf_wdata;

   always_comb begin
      buf_we    = 1'b0;
      buf_widx  = '0;
      buf_wdata = in_pkt_data;
      if (state == S_EXEC) begin
         buf_we            = 1'b1;
         buf_widx          = IW'(CMD_WORD);
         buf_wdata         = cmd;
         buf_wdata[119:56] = exec_data;
         buf_wdata[49]     = exec_err;
      end else if (take && is_head && (state == S_IDLE || state == S_RECV)) begin
         buf_we = 1'b1;
      end else if (take && (state == S_RECV) && !buf_full) begin
         buf_we   = 1'b1;
         buf_widx = wcnt[IW-1:0];
      end
   end

   // Buffer contents are pure data; wcnt alone decides what is live.
   always_ff @(posedge clk) begin
      if (buf_we) pkt_buf[buf_widx] <= buf_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= S_IDLE;
         wcnt                  <= '0;
         rd_idx                <= '0;
         in_pkt_data_ready     <= 1'b1;
         out_pkt_data          <= '0;
         out_pkt_data_wr       <= 1'b0;
         out_pkt_data_valid    <= 1'b0;
         out_pkt_data_valid_wr <= 1'b0;
         cfg_regs              <= {NUM_REGS{REG_RST[REG_W-1:0]}};
         cfg_wr_pulse          <= '0;
         drop_cnt              <= '0;
      end else begin
         out_pkt_data_wr       <= 1'b0;
         out_pkt_data_valid_wr <= 1'b0;
         cfg_wr_pulse          <= '0;
         if (drop_ev && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         case (state)
            S_IDLE: begin
               in_pkt_data_ready <= 1'b1;
               if (take && is_head) begin
                  wcnt  <= CW'(1);
                  state <= S_RECV;
               end
            end
            S_RECV: begin
               if (take) begin
                  if (is_head) begin
                     wcnt <= CW'(1);
                  end else if (buf_full) begin
                     state <= is_tail ? S_IDLE : S_FLUSH;
                  end else begin
                     wcnt <= wcnt + CW'(1);
                     if (is_tail) begin
                        if (good_tail) begin
                           state             <= S_EXEC;
                           in_pkt_data_ready <= 1'b0;
                        end else begin
                           state <= S_IDLE;
                        end
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (take && is_tail) state <= S_IDLE;
            end
            S_EXEC: begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (reg_hit[i] && !rd) cfg_regs[i*REG_W +: REG_W] <= wtrunc;
               end
               cfg_wr_pulse <= reg_hit & {NUM_REGS{!rd}};
               rd_idx       <= '0;
               state        <= S_SEND;
            end
            S_SEND: begin
               if (out_pkt_data_ready) begin
                  out_pkt_data    <= pkt_buf[rd_idx[IW-1:0]];
                  out_pkt_data_wr <= 1'b1;
                  if (rd_idx == wcnt - CW'(1)) begin
                     out_pkt_data_valid_wr <= 1'b1;
                     out_pkt_data_valid    <= 1'b1;
                     state                 <= S_IDLE;
                  end else begin
                     rd_idx <= rd_idx + CW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_cfg_bank.sv
// tb/tb_lcm_cfg_bank.sv - directed and randomized packets against a register-bank model.
module tb_lcm_cfg_bank;
   localparam int NR = 8;
   localparam int NS = 4;
   localparam int RW = 16;
   localparam int MW = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [133:0]       in_data;
   logic               in_wr, in_valid, in_valid_wr, in_ready;
   logic [133:0]       out_data;
   logic               out_wr, out_valid, out_valid_wr, out_ready;
   logic [NR*RW-1:0]   cfg_regs;
   logic [NR-1:0]      cfg_wr_pulse;
   logic [NS*64-1:0]   stat_in;
   logic [15:0]        drop_cnt;

   always #5 clk = ~clk;

   lcm_cfg_bank #(
      .NUM_REGS(NR), .NUM_STAT(NS), .REG_W(RW), .MAX_WORDS(MW),
      .CMD_WORD(0), .REG_RST(64'h5A5A)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_pkt_data(in_data), .in_pkt_data_wr(in_wr),
      .in_pkt_data_valid(in_valid), .in_pkt_data_valid_wr(in_valid_wr),
      .in_pkt_data_ready(in_ready),
      .out_pkt_data(out_data), .out_pkt_data_wr(out_wr),
      .out_pkt_data_valid(out_valid), .out_pkt_data_valid_wr(out_valid_wr),
      .out_pkt_data_ready(out_ready),
      .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse),
      .stat_in(stat_in), .drop_cnt(drop_cnt)
   );

   int           n_asrt = 0;
   int           n_fail = 0;
   int           m_drop = 0;
   logic [15:0]  m_regs [NR];
   logic [63:0]  m_stat [NS];
   logic [133:0] pkt[$];
   logic [133:0] rx_q[$];

   task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*RW-1:0] mflat();
      logic [NR*RW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*RW +: RW] = m_regs[i];
      return f;
   endfunction

   task automatic build_pkt(input int n, input bit rd, input logic [47:0] addr,
                            input logic [63:0] data);
      pkt.delete();
      for (int i = 0; i < n; i++) begin
         logic [133:0] w;
         w = 134'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         w[133:132] = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
         if (i == 0) begin
            w[119:56] = data;
            w[48]     = rd;
            w[47:0]   = addr;
         end
         pkt.push_back(w);
      end
   endtask

   task automatic send_words(input bit valid);
      foreach (pkt[i]) begin
         @(negedge clk);
         in_data     = pkt[i];
         in_wr       = 1'b1;
         in_valid_wr = (pkt[i][133:132] == 2'b10);
         in_valid    = valid && in_valid_wr;
      end
      @(negedge clk);
      in_wr       = 1'b0;
      in_valid_wr = 1'b0;
      in_valid    = 1'b0;
   endtask

   // mode 0: ready held high (latency checked); 1: random ready; 2: 5-cycle stall after 3 words
   task automatic do_txn(input string tag, input int n, input bit rd, input logic [47:0] addr,
                         input logic [63:0] data, input int mode);
      logic [NR*RW-1:0] old_flat, new_flat;
      logic [NR-1:0]    exp_pulse;
      logic [63:0]      d;
      logic             err;
      logic [133:0]     mask;
      logic [133:0]     exp_q[$];
      int               k, stall_cnt;
      bit               done, prev_rdy;

      build_pkt(n, rd, addr, data);
      old_flat  = mflat();
      exp_pulse = '0;
      d         = data;
      err       = 1'b0;
      mask      = '1;
      if (addr < 48'(NR)) begin
         if (rd) begin
            d = 64'(m_regs[addr[2:0]]);
         end else begin
            m_regs[addr[2:0]]    = data[RW-1:0];
            d                    = 64'(data[RW-1:0]);
            exp_pulse[addr[2:0]] = 1'b1;
         end
      end else if (addr < 48'(NR + NS) && rd) begin
         d = m_stat[addr[1:0]];
      end else begin
         err = 1'b1;
         if (rd) d = '0;
      end
      if (err && !rd) mask[119:56] = '0;
      new_flat = mflat();
      exp_q = pkt;
      exp_q[0][119:56] = d;
      exp_q[0][49]     = err;

      send_words(1'b1);
      rx_q.delete();
      k = 1; stall_cnt = 0; done = 1'b0; prev_rdy = 1'b1;
      while (k <= 200 && !done) begin
         if (!prev_rdy) chk({tag, "_wr_after_stall"}, 134'(out_wr), 134'(0));
         chk({tag, "_in_ready_low"}, 134'(in_ready), 134'(0));
         if (k == 1) chk({tag, "_regs_before"}, 134'(cfg_regs), 134'(old_flat));
         if (k == 2) begin
            chk({tag, "_pulse"}, 134'(cfg_wr_pulse), 134'(exp_pulse));
            chk({tag, "_regs_after"}, 134'(cfg_regs), 134'(new_flat));
         end else if (cfg_wr_pulse !== '0) begin
            chk({tag, "_pulse_extra"}, 134'(cfg_wr_pulse), 134'(0));
         end
         if (out_wr) begin
            rx_q.push_back(out_data);
            if (mode == 0 && rx_q.size() == 1) chk({tag, "_first_lat"}, 134'(k), 134'(3));
         end
         if (out_valid_wr) begin
            done = 1'b1;
            chk({tag, "_tail_wr"}, 134'(out_wr), 134'(1));
            chk({tag, "_tail_valid"}, 134'(out_valid), 134'(1));
            chk({tag, "_word_cnt"}, 134'(rx_q.size()), 134'(n));
            if (mode == 0) chk({tag, "_last_lat"}, 134'(k), 134'(n + 2));
         end
         case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               out_ready = !(rx_q.size() >= 3 && stall_cnt < 5);
               if (!out_ready) stall_cnt++;
            end
            default: out_ready = 1'b1;
         endcase
         prev_rdy = out_ready;
         @(negedge clk);
         k++;
      end
      out_ready = 1'b1;
      if (!done) chk({tag, "_resp_timeout"}, 134'(0), 134'(1));
      chk({tag, "_in_ready_back"}, 134'(in_ready), 134'(1));
      for (int i = 0; i < n && i < rx_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), rx_q[i] & ((i == 0) ? mask : '1),
             exp_q[i] & ((i == 0) ? mask : '1));
      chk({tag, "_regs"}, 134'(cfg_regs), 134'(mflat()));
      chk({tag, "_drop"}, 134'(drop_cnt), 134'(m_drop));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 134'(in_ready), 134'(1));
      chk({tag, "_out_data"}, out_data, 134'(0));
      chk({tag, "_out_wr"}, 134'(out_wr), 134'(0));
      chk({tag, "_out_valid"}, 134'(out_valid), 134'(0));
      chk({tag, "_out_valid_wr"}, 134'(out_valid_wr), 134'(0));
      chk({tag, "_regs"}, 134'(cfg_regs), 134'(mflat()));
      chk({tag, "_pulse"}, 134'(cfg_wr_pulse), 134'(0));
      chk({tag, "_drop"}, 134'(drop_cnt), 134'(0));
   endtask

   initial begin
      int            cnt;
      logic [47:0]   a;
      rst_n = 1'b0; in_data = '0; in_wr = 1'b0; in_valid = 1'b0; in_valid_wr = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < NS; j++) m_stat[j] = {$urandom(), $urandom()};
      m_stat[0] = 64'hDEAD_BEEF;
      stat_in = {m_stat[3], m_stat[2], m_stat[1], m_stat[0]};
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h5A5A;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      do_txn("wr2", 6, 1'b0, 48'd2, 64'h1234, 0);
      do_txn("rd2", 6, 1'b1, 48'd2, 64'h0, 0);
      do_txn("rd_stat0", 4, 1'b1, 48'd8, 64'h0, 0);
      do_txn("wr_stat0", 4, 1'b0, 48'd8, 64'h5555, 0);
      do_txn("rd_0x100", 3, 1'b1, 48'h100, 64'h0, 0);
      do_txn("wr_trunc", 2, 1'b0, 48'd1, 64'hABCD_1234, 0);
      do_txn("wr_alias", 3, 1'b0, {16'h0001, 32'd3}, 64'h7777, 0);
      do_txn("rd_last", 5, 1'b1, 48'd11, 64'h0, 0);

      build_pkt(4, 1'b1, 48'd2, 64'h0);
      send_words(1'b0);
      m_drop++;
      for (int c = 0; c < 5; c++) begin
         chk("bad_valid_no_resp", 134'(out_wr), 134'(0));
         @(negedge clk);
      end
      chk("bad_valid_drop", 134'(drop_cnt), 134'(m_drop));
      build_pkt(10, 1'b1, 48'd2, 64'h0);
      send_words(1'b1);
      m_drop++;
      for (int c = 0; c < 5; c++) begin
         chk("long_no_resp", 134'(out_wr), 134'(0));
         @(negedge clk);
      end
      chk("long_drop", 134'(drop_cnt), 134'(m_drop));
      do_txn("rd_after_drop", 6, 1'b1, 48'd2, 64'h0, 0);
      build_pkt(3, 1'b0, 48'd4, 64'h9999);
      void'(pkt.pop_back());
      send_words(1'b1);
      m_drop++;
      do_txn("restart", 4, 1'b0, 48'd5, 64'h4321, 0);

      do_txn("stall", 7, 1'b1, 48'd5, 64'h0, 2);

      build_pkt(7, 1'b1, 48'd3, 64'h0);
      send_words(1'b1);
      cnt = 0;
      for (int c = 0; c < 30 && cnt < 2; c++) begin
         if (out_wr) cnt++;
         if (cnt < 2) @(negedge clk);
      end
      chk("pre_reset_words", 134'(cnt), 134'(2));
      #2 rst_n = 1'b0;
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h5A5A;
      m_drop = 0;
      #1 chk_reset_outputs("mid_send_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk("post_reset_quiet", 134'(out_wr), 134'(0));
         @(negedge clk);
      end
      do_txn("post_reset_rd", 5, 1'b1, 48'd3, 64'h0, 0);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: a = 48'($urandom_range(0, NR + NS - 1));
            7:                   a = 48'($urandom_range(NR + NS, 15));
            8:                   a = {16'h0001, 32'($urandom_range(0, NR + NS - 1))};
            default:             a = 48'({$urandom(), $urandom()});
         endcase
         do_txn($sformatf("rand%0d", t), $urandom_range(2, MW), 1'($urandom_range(0, 1)),
                a, {$urandom(), $urandom()}, $urandom_range(0, 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
